// File: rtl/crc_pkg.sv
// Shared definitions for the bit-serial CRC-8 block: FSM encoding, default
// polynomial/initial remainder, bit counter width and its saturating increment.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_e;

    // Plain-vector views of the state encoding for the state register.
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;
    localparam logic [7:0] CRC_INIT_DEFAULT = 8'h00;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/crc8_step.sv
// One MSB-first CRC-8 step: shift the remainder left and fold the polynomial
// in when the feedback bit (crc[7] ^ data) is set. Purely combinational.
module crc8_step (
    input  logic [7:0] i_crc,
    input  logic       i_bit,
    input  logic [7:0] i_poly,
    output logic [7:0] o_crc
);

    logic       w_fb;
    logic [7:0] w_shift;

    assign w_fb    = i_crc[7] ^ i_bit;
    assign w_shift = {i_crc[6:0], 1'b0};

    // One XOR per tap so each can be replaced by a switch-level XOR cell.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tap
            assign o_crc[gi] = w_shift[gi] ^ (i_poly[gi] & w_fb);
        end
    endgenerate

endmodule

// File: rtl/serial_crc8.sv
// Bit-serial CRC-8 generator/checker: frames a serial stream with start/last,
// pulses crc_valid with the final remainder and flags a zero residue.
module serial_crc8
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY_DEFAULT,
    parameter logic [7:0] INIT = CRC_INIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             last,
    output logic             busy,
    output logic [7:0]       crc_out,
    output logic             crc_valid,
    output logic             match,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [7:0]       r_crc;
    logic [7:0]       w_crc_next;
    logic [7:0]       w_crc_base;
    logic [7:0]       w_crc_step;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic             w_accept;
    logic             w_in_frame;

    // start reinitialises first, so a bit arriving with start is stepped from INIT.
    assign w_accept   = bit_valid && (start || (r_state == S_SHIFT));
    assign w_in_frame = start || (r_state == S_SHIFT);
    assign w_crc_base = start ? INIT : r_crc;
    assign w_cnt_base = start ? '0 : r_cnt;

    crc8_step u_step (
        .i_crc  (w_crc_base),
        .i_bit  (bit_in),
        .i_poly (POLY),
        .o_crc  (w_crc_step)
    );

    always_comb begin
        w_crc_next   = w_crc_base;
        w_cnt_next   = w_cnt_base;
        w_state_next = S_IDLE;
        if (w_accept) begin
            w_crc_next = w_crc_step;
            w_cnt_next = sat_inc(w_cnt_base);
        end
        if (w_in_frame) begin
            w_state_next = (w_accept && last) ? S_DONE : S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_crc   <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_crc   <= w_crc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign busy      = (r_state == S_SHIFT);
    assign crc_valid = (r_state == S_DONE);
    assign match     = crc_valid && (r_crc == 8'h00);
    assign crc_out   = r_crc;
    assign bit_cnt   = r_cnt;

endmodule

// File: tb/tb_serial_crc8.sv
// Directed bench for serial_crc8: frames are driven serially, expected final
// results are queued on the last bit and compared when crc_valid pulses.
module tb_serial_crc8;
    import crc_pkg::*;

    logic             clk;
    logic             rst;
    logic             start;
    logic             bit_valid;
    logic             bit_in;
    logic             last;
    logic             busy;
    logic [7:0]       crc_out;
    logic             crc_valid;
    logic             match;
    logic [CNT_W-1:0] bit_cnt;

    typedef struct packed {
        logic [7:0]  crc;
        logic        m;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    serial_crc8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .last      (last),
        .busy      (busy),
        .crc_out   (crc_out),
        .crc_valid (crc_valid),
        .match     (match),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last      = 1'b0;
        repeat (n) tick();
    endtask

    // Drives nbits of data MSB first; start accompanies the first bit.
    task automatic send_frame(input logic [71:0] data, input int nbits,
                              input logic [7:0] ecrc, input logic em);
        for (int i = nbits - 1; i >= 0; i--) begin
            start     = (i == nbits - 1);
            bit_valid = 1'b1;
            bit_in    = data[i];
            last      = (i == 0);
            if (i == 0) sb_q.push_back('{ecrc, em, 16'(nbits)});
            tick();
            if (i == nbits - 1 && nbits > 1) chk("busy_in_frame", busy, 1);
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        last      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (crc_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("valid_without_frame", crc_valid, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("final_crc", crc_out, e.crc);
                chk("final_match", match, e.m);
                chk("final_bit_cnt", bit_cnt, e.cnt);
                $display("frame done: crc=%02h match=%0d bits=%0d (expect %02h/%0d/%0d)",
                         crc_out, match, bit_cnt, e.crc, e.m, e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; last = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_crc_out", crc_out, 8'h00);
        chk("rst_crc_valid", crc_valid, 0);
        chk("rst_match", match, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        rst = 1'b0;
        idle(1);

        // "123456789"
        send_frame(72'h313233343536373839, 72, 8'hF4, 1'b0);
        idle(3);
        chk("busy_after_frame", busy, 0);
        chk("hold_crc_out", crc_out, 8'hF4);
        chk("hold_bit_cnt", bit_cnt, 72);

        send_frame(72'h01, 8, 8'h07, 1'b0);
        idle(2);

        // bit_valid/last in IDLE must be ignored
        bit_valid = 1'b1; bit_in = 1'b1; last = 1'b1;
        tick();
        tick();
        idle(1);
        chk("idle_ignore_crc", crc_out, 8'h07);
        chk("idle_ignore_cnt", bit_cnt, 8);
        chk("idle_ignore_busy", busy, 0);

        send_frame(72'h0107, 16, 8'h00, 1'b1);
        idle(2);
        send_frame(72'h00, 8, 8'h00, 1'b1);
        idle(2);

        // abort after 5 bits, restart with 0x01
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; last = 1'b0;
        tick();
        start = 1'b0;
        bit_in = 1'b0; tick();
        bit_in = 1'b1; tick();
        bit_in = 1'b1; tick();
        bit_in = 1'b0; tick();
        chk("abort_partial_cnt", bit_cnt, 5);
        chk("abort_partial_busy", busy, 1);
        send_frame(72'h01, 8, 8'h07, 1'b0);
        idle(2);
        chk("abort_final_cnt", bit_cnt, 8);

        // single-bit frame: start + bit_valid + last together
        send_frame(72'h1, 1, 8'h07, 1'b0);
        idle(2);
        chk("single_bit_cnt", bit_cnt, 1);

        // back-to-back: second start lands in DONE
        send_frame(72'hFF, 8, 8'hF3, 1'b0);
        send_frame(72'h01, 8, 8'h07, 1'b0);
        idle(2);

        // reset mid-frame with last on the same edge
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; last = 1'b0;
        tick();
        start = 1'b0;
        repeat (5) tick();
        last = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0; bit_valid = 1'b0; last = 1'b0;
        chk("rst_mid_crc_valid", crc_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_crc_out", crc_out, 8'h00);
        chk("rst_mid_bit_cnt", bit_cnt, 0);
        idle(3);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
